// File: rtl/mem88_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem88_responder
// Brief    : Byte-bus responder pacing an 8088-class core against an async
//            8-bit SRAM, with a one-entry last-read hit register.
//            Optional macro MEM88_ROM_PROTECT_EN drops writes at/above ROM_BASE.
// Revision : 1.0 - initial release
// ============================================================================
module mem88_responder #(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [19:0] ROM_BASE    = 20'hF0000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic [19:0] address,
   input  logic [7:0]  data,
   input  logic        wreq,
   output logic [7:0]  bus,
   output logic        locked,
   output logic [19:0] sram_addr,
   output logic [7:0]  sram_dout,
   input  logic [7:0]  sram_din,
   output logic        sram_ce_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   localparam int c_wait  = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
   localparam int c_cnt_w = (c_wait > 1) ? $clog2(c_wait) : 1;
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(c_wait - 1);

`ifdef MEM88_ROM_PROTECT_EN
   localparam logic c_rom_protect = 1'b1;
`else
   localparam logic c_rom_protect = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD       = 3'd1,
      S_WR_SETUP = 3'd2,
      S_WR_PULSE = 3'd3,
      S_STEP     = 3'd4
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [19:0]          r_tag, w_tag_nxt;
   logic                 r_valid, w_valid_nxt;
   logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
   logic [19:0]          r_a_q, w_a_q_nxt;
   logic [7:0]           r_d_q, w_d_q_nxt;
   logic [7:0]           w_bus_nxt;
   logic                 w_locked_nxt;
   logic [19:0]          w_addr_nxt;
   logic [7:0]           w_dout_nxt;
   logic                 w_ce_n_nxt, w_oe_n_nxt, w_we_n_nxt;
   logic                 w_rom_block;

   assign w_rom_block = c_rom_protect & wreq & (address >= ROM_BASE);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state   <= S_IDLE;
         r_tag     <= '0;
         r_valid   <= 1'b0;
         r_cnt     <= '0;
         r_a_q     <= '0;
         r_d_q     <= '0;
         bus       <= '0;
         locked    <= 1'b0;
         sram_addr <= '0;
         sram_dout <= '0;
         sram_ce_n <= 1'b1;
         sram_oe_n <= 1'b1;
         sram_we_n <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_tag     <= w_tag_nxt;
         r_valid   <= w_valid_nxt;
         r_cnt     <= w_cnt_nxt;
         r_a_q     <= w_a_q_nxt;
         r_d_q     <= w_d_q_nxt;
         bus       <= w_bus_nxt;
         locked    <= w_locked_nxt;
         sram_addr <= w_addr_nxt;
         sram_dout <= w_dout_nxt;
         sram_ce_n <= w_ce_n_nxt;
         sram_oe_n <= w_oe_n_nxt;
         sram_we_n <= w_we_n_nxt;
      end
   end

   // locked defaults low so it is a single-cycle pulse on every entry to STEP
   always_comb begin
      w_state_nxt  = r_state;
      w_tag_nxt    = r_tag;
      w_valid_nxt  = r_valid;
      w_cnt_nxt    = r_cnt;
      w_a_q_nxt    = r_a_q;
      w_d_q_nxt    = r_d_q;
      w_bus_nxt    = bus;
      w_locked_nxt = 1'b0;
      w_addr_nxt   = sram_addr;
      w_dout_nxt   = sram_dout;
      w_ce_n_nxt   = sram_ce_n;
      w_oe_n_nxt   = sram_oe_n;
      w_we_n_nxt   = sram_we_n;

      case (r_state)
         S_IDLE: begin
            w_a_q_nxt = address;
            w_d_q_nxt = data;
            if (w_rom_block) begin
               w_locked_nxt = 1'b1;
               w_state_nxt  = S_STEP;
            end else if (wreq) begin
               w_addr_nxt  = address;
               w_dout_nxt  = data;
               w_ce_n_nxt  = 1'b0;
               w_state_nxt = S_WR_SETUP;
            end else if (r_valid && (address == r_tag)) begin
               w_locked_nxt = 1'b1;
               w_state_nxt  = S_STEP;
            end else begin
               w_addr_nxt  = address;
               w_ce_n_nxt  = 1'b0;
               w_oe_n_nxt  = 1'b0;
               w_cnt_nxt   = c_cnt_init;
               w_state_nxt = S_RD;
            end
         end

         S_RD: begin
            if (r_cnt == '0) begin
               w_bus_nxt    = sram_din;
               w_tag_nxt    = r_a_q;
               w_valid_nxt  = 1'b1;
               w_ce_n_nxt   = 1'b1;
               w_oe_n_nxt   = 1'b1;
               w_locked_nxt = 1'b1;
               w_state_nxt  = S_STEP;
            end else begin
               w_cnt_nxt = r_cnt - c_cnt_w'(1);
            end
         end

         S_WR_SETUP: begin
            w_we_n_nxt  = 1'b0;
            w_cnt_nxt   = c_cnt_init;
            w_state_nxt = S_WR_PULSE;
         end

         // write-through into the hit register keeps it coherent with SRAM
         S_WR_PULSE: begin
            if (r_cnt == '0) begin
               w_we_n_nxt   = 1'b1;
               w_ce_n_nxt   = 1'b1;
               w_tag_nxt    = r_a_q;
               w_bus_nxt    = r_d_q;
               w_valid_nxt  = 1'b1;
               w_locked_nxt = 1'b1;
               w_state_nxt  = S_STEP;
            end else begin
               w_cnt_nxt = r_cnt - c_cnt_w'(1);
            end
         end

         S_STEP: begin
            w_state_nxt = S_IDLE;
         end

         default: begin
            w_ce_n_nxt  = 1'b1;
            w_oe_n_nxt  = 1'b1;
            w_we_n_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/mem88_responder.md
Name: mem88_responder

Overview:
Bus responder for the 8088-class core's byte bus. It presents the core's 20-bit address, write data and write request to an external asynchronous 8-bit SRAM, and paces the core through its `locked` step-enable input. The core advances exactly one micro-step per completed memory transaction. A one-entry last-read register lets repeated reads of the same address complete without an SRAM access.

Parameters:
WAIT_CYCLES, 2, SRAM strobe width in clocks for read (OE) and write (WE); values <1 treated as 1
ROM_BASE, 20'hF0000, lowest write-protected address (used only with the optional feature)

Ports:
clock  in  1  system clock
resetn  in  1  reset, synchronous, active-low
address  in  20  core bus address
data  in  8  core write data
wreq  in  1  core write request (1 = write, 0 = read)
bus  out  8  read data to core; registered
locked  out  1  core step enable; high for exactly one clock per completed transaction
sram_addr  out  20  SRAM address, registered
sram_dout  out  8  SRAM write data, registered
sram_din  in  8  SRAM read data
sram_ce_n  out  1  SRAM chip enable, active-low
sram_oe_n  out  1  SRAM output enable, active-low
sram_we_n  out  1  SRAM write enable, active-low

Behaviour:
- One clock, `clock`; synchronous active-low reset `resetn`.
- Reset values: locked=0, bus=0, sram_ce_n=sram_oe_n=sram_we_n=1, sram_addr=0, sram_dout=0, tag=0, valid=0, cnt=0, state=IDLE.
- Reset takes priority in any state. The first edge with resetn=0 deasserts all strobes and locked.
- States: IDLE, RD, WR_SETUP, WR_PULSE, STEP.
- IDLE: latch a_q=address, w_q=wreq, d_q=data. Then:
  - read with valid=1 and address==tag (hit): go to STEP; no strobes asserted.
  - read miss: sram_addr<=address, ce_n<=0, oe_n<=0, cnt<=WAIT_CYCLES-1; go to RD.
  - write: sram_addr<=address, sram_dout<=data, ce_n<=0; go to WR_SETUP.
- RD:
  - if cnt==0: bus<=sram_din, tag<=a_q, valid<=1, ce_n<=1, oe_n<=1; go to STEP.
  - else cnt<=cnt-1.
- WR_SETUP: one clock with address and data stable; we_n<=0, cnt<=WAIT_CYCLES-1; go to WR_PULSE.
- WR_PULSE:
  - if cnt==0: we_n<=1, ce_n<=1, tag<=a_q, bus<=d_q, valid<=1 (write-through keeps the hit register coherent); go to STEP.
  - else cnt<=cnt-1.
- STEP and locked:
  - locked<=1 on entry to STEP; locked is high for the whole STEP cycle.
  - bus is stable throughout the STEP cycle.
  - On the next edge: locked<=0, go to IDLE.
  - The core updates address/wreq/data on that edge; IDLE samples the new values.
- Cycles per core step, measured from the IDLE cycle through the locked cycle inclusive:
  - hit: 2
  - read miss: WAIT_CYCLES+2
  - write: WAIT_CYCLES+3
- sram_oe_n and sram_we_n are never low simultaneously. sram_ce_n is low whenever either of them is low.
- No stalls from SRAM; timing is fixed by WAIT_CYCLES.
- Address compare is a full 20-bit compare. There is no wrap or alias handling; address is passed through unchanged.
- valid is cleared only by reset.

Optional Feature:
MEM88_ROM_PROTECT_EN
- Defined: a write with address>=ROM_BASE asserts no SRAM strobes and leaves tag/valid/bus unchanged. IDLE goes directly to STEP, so the write costs 2 cycles. Reads of that region behave normally.
- Undefined: all writes go to SRAM as described; ROM_BASE is unused.

Test Plan:
- Reset: hold resetn=0 for 3 clocks, wreq=0 -> locked=0, bus=0, all strobes=1; after release, the first transaction starts in IDLE.
- Read miss, WAIT_CYCLES=2: address=20'h12345, sram_din=8'hA5 -> sram_addr=12345, oe_n/ce_n low exactly 2 clocks, locked high on the 4th clock for 1 clock, bus=A5.
- Read hit: same address 12345 on the next step -> no strobe activity, locked high on the 2nd clock, bus=A5.
- Write then read: write 20'h00100 data 8'h5A -> ce_n low 3 clocks, we_n low 2 clocks, sram_dout=5A, locked on the 5th clock; next read of 00100 hits, bus=5A, no SRAM access.
- ROM protect (macro defined): write 20'hF0010 data 8'h77 -> strobes stay high, locked on the 2nd clock, subsequent read of F0010 is a miss; without the macro the write occurs normally.
- Reset mid-operation: assert resetn=0 during RD cycle 1 -> next edge oe_n=ce_n=1, locked=0, valid=0; the next read of 12345 is a miss.
